// File: rtl/decoder_n_to_m_reg_if.sv
// ---------------------------------------------------------------------------
// decoder_n_to_m_reg_if
// Bundle of request and result signals for decoder_n_to_m_reg.
//   din   : select value to decode (SEL_W bits)
//   en    : decode request
//   clr   : clear held output (only meaningful in hold mode)
//   y     : registered one-hot decode result (NUM_OUT bits)
//   valid : y carries a legal decode
//   err   : one-cycle pulse for an accepted out-of-range request
//   cnt   : saturating count of legal decodes (CNT_W bits)
// Modports: master drives requests, slave (the decoder) drives results.
// ---------------------------------------------------------------------------
interface decoder_n_to_m_reg_if #(
   parameter int SEL_W   = 3,
   parameter int NUM_OUT = 8,
   parameter int CNT_W   = 8
);
   logic [SEL_W-1:0]   din;
   logic               en;
   logic               clr;
   logic [NUM_OUT-1:0] y;
   logic               valid;
   logic               err;
   logic [CNT_W-1:0]   cnt;

   modport master (
      output din, en, clr,
      input  y, valid, err, cnt
   );

   modport slave (
      input  din, en, clr,
      output y, valid, err, cnt
   );
endinterface

// File: rtl/decoder_n_to_m_reg.sv
// ---------------------------------------------------------------------------
// decoder_n_to_m_reg
// Registered N-to-M one-hot decoder with range checking and a saturating
// count of accepted legal decodes.
//   clk   : rising-edge clock for all state
//   reset : synchronous, active-high reset (clears y, valid, err, cnt)
//   bus   : slave side of decoder_n_to_m_reg_if
//           din/en/clr in; y/valid/err/cnt out, all registered
// Parameters:
//   SEL_W   : select width
//   NUM_OUT : number of one-hot outputs, 2 .. 2**SEL_W
//   MODE    : 0 = pulse (y lasts one cycle per request), 1 = hold
//   CNT_W   : width of the accepted-decode counter
// A request is sampled at a rising edge and its result appears after that
// same edge. In hold mode, clr wins over a simultaneous en and that request
// is dropped entirely (no count, no err).
// ---------------------------------------------------------------------------
module decoder_n_to_m_reg #(
   parameter int SEL_W   = 3,
   parameter int NUM_OUT = 8,
   parameter int MODE    = 0,
   parameter int CNT_W   = 8
) (
   input logic                 clk,
   input logic                 reset,
   decoder_n_to_m_reg_if.slave bus
);

   localparam bit HOLD = (MODE == 1);

   logic [NUM_OUT-1:0] y_q,     y_nxt;
   logic               valid_q, valid_nxt;
   logic               err_q,   err_nxt;
   logic [CNT_W-1:0]   cnt_q,   cnt_nxt;
   logic               legal;
   logic               clr_act;

   // With NUM_OUT == 2**SEL_W every select is in range, so err can never fire.
   assign legal   = (int'(bus.din) < NUM_OUT);
   assign clr_act = HOLD && bus.clr;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      y_nxt     = HOLD ? y_q     : '0;
      valid_nxt = HOLD ? valid_q : 1'b0;
      err_nxt   = 1'b0;
      cnt_nxt   = cnt_q;

      if (clr_act) begin
         // The simultaneous request (if any) is dropped.
         y_nxt     = '0;
         valid_nxt = 1'b0;
      end else if (bus.en) begin
         if (legal) begin
            // Rebuilding the whole vector clears the old bit and sets the new
            // one on the same edge, so a replaced hold never shows a zero gap.
            for (int k = 0; k < NUM_OUT; k++) begin
               y_nxt[k] = (int'(bus.din) == k);
            end
            valid_nxt = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_nxt = cnt_q + 1'b1;
            end
         end else begin
            y_nxt     = '0;
            valid_nxt = 1'b0;
            err_nxt   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         y_q     <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         y_q     <= y_nxt;
         valid_q <= valid_nxt;
         err_q   <= err_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   assign bus.y     = y_q;
   assign bus.valid = valid_q;
   assign bus.err   = err_q;
   assign bus.cnt   = cnt_q;

endmodule
